// File: rtl/wb_wport_arbiter_pkg.sv
// Shared widths, arbiter state encoding and late-result entry layout for the
// writeback write-port arbiter.
package wb_wport_arbiter_pkg;

  localparam int REG_ADDR_BUS   = 5;
  localparam int REG_BUS        = 32;
  localparam int DOUBLE_REG_BUS = 64;
  localparam logic [REG_BUS-1:0] ZERO_WORD = 32'h0000_0000;

  localparam int WB_WPORT_DEPTH      = 2;
  localparam int WB_WPORT_STARVE_MAX = 4;

  typedef enum logic [0:0] {
    ARB_PIPE = 1'b0,
    ARB_LAT  = 1'b1
  } arb_state_e;

  // Late-result FIFO entry: 1 + 5 + 64 = 70 bits.
  typedef struct packed {
    logic                      hilo;
    logic [REG_ADDR_BUS-1:0]   wa;
    logic [DOUBLE_REG_BUS-1:0] data;
  } lat_entry_t;

  // A GPR write to r0 is architecturally a no-op and never claims the port.
  function automatic logic gpr_req(input logic we, input logic [REG_ADDR_BUS-1:0] wa);
    return we & (wa != 5'd0);
  endfunction

endpackage

// File: rtl/wb_lat_fifo.sv
// Synchronous FIFO holding late results (hilo flag, GPR address, data) until
// the arbiter can retire them onto a write port.
module wb_lat_fifo
  import wb_wport_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_WPORT_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  lat_entry_t             push_data_i,
  input  logic                   pop_i,
  output logic                   full_o,
  output logic                   head_valid_o,
  output lat_entry_t             head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   hilo_busy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  lat_entry_t        mem_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push_s;
  logic              do_pop_s;

  // No bypass: a full FIFO refuses a push even when it pops in the same cycle.
  assign do_push_s    = push_i & (count_q != DEPTH_C);
  assign do_pop_s     = pop_i & (count_q != {CNT_W{1'b0}});
  assign full_o       = (count_q == DEPTH_C);
  assign head_valid_o = (count_q != {CNT_W{1'b0}});
  assign head_o       = mem_q[rd_ptr_q];
  assign count_o      = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_s) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    hilo_busy_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && mem_q[i].hilo) begin
        hilo_busy_o = 1'b1;
      end else begin
        hilo_busy_o = hilo_busy_o;
      end
    end
  end

endmodule

// File: rtl/wb_wport_arbiter.sv
// Shares the GPR and HILO write ports between the in-order writeback stage and
// queued late results, with an anti-starvation override that stalls the pipe.
module wb_wport_arbiter
  import wb_wport_arbiter_pkg::*;
#(
  parameter int DEPTH      = WB_WPORT_DEPTH,
  parameter int STARVE_MAX = WB_WPORT_STARVE_MAX
) (
  input  logic                      cpu_clk_50M,
  input  logic                      cpu_rst,
  input  logic                      pipe_wreg_i,
  input  logic [REG_ADDR_BUS-1:0]   pipe_wa_i,
  input  logic [REG_BUS-1:0]        pipe_wd_i,
  input  logic                      pipe_whilo_i,
  input  logic [DOUBLE_REG_BUS-1:0] pipe_dhilo_i,
  input  logic                      lat_valid_i,
  output logic                      lat_ready_o,
  input  logic                      lat_hilo_i,
  input  logic [REG_ADDR_BUS-1:0]   lat_wa_i,
  input  logic [DOUBLE_REG_BUS-1:0] lat_data_i,
  output logic                      rf_we_o,
  output logic [REG_ADDR_BUS-1:0]   rf_wa_o,
  output logic [REG_BUS-1:0]        rf_wd_o,
  output logic                      hilo_we_o,
  output logic [REG_BUS-1:0]        hi_o,
  output logic [REG_BUS-1:0]        lo_o,
  output logic                      wb_stall_o,
  output logic                      hilo_busy_o,
  output logic [$clog2(DEPTH):0]    lat_cnt_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_MAX) + 1;
  localparam logic [STV_W-1:0] STARVE_LAST = STV_W'(STARVE_MAX - 1);

  arb_state_e        state_q, state_d;
  logic [STV_W-1:0]  starve_q, starve_d;

  lat_entry_t        push_data_s;
  lat_entry_t        head_s;
  logic              head_valid_s;
  logic              fifo_full_s;
  logic              fifo_busy_s;
  logic [CNT_W-1:0]  fifo_cnt_s;
  logic              push_s;
  logic              pop_s;

  logic              h_gpr_s, h_hilo_s, p_gpr_s, p_hilo_s, conflict_s;
  logic              head_en_s, pipe_en_s, stall_s;

  assign push_data_s = '{hilo: lat_hilo_i, wa: lat_wa_i, data: lat_data_i};
  assign push_s      = lat_valid_i & lat_ready_o;

  wb_lat_fifo #(
    .DEPTH (DEPTH)
  ) u_lat_fifo (
    .clk_i        (cpu_clk_50M),
    .rst_i        (cpu_rst),
    .push_i       (push_s),
    .push_data_i  (push_data_s),
    .pop_i        (pop_s),
    .full_o       (fifo_full_s),
    .head_valid_o (head_valid_s),
    .head_o       (head_s),
    .count_o      (fifo_cnt_s),
    .hilo_busy_o  (fifo_busy_s)
  );

  assign h_gpr_s    = head_valid_s & ~head_s.hilo & (head_s.wa != 5'd0);
  assign h_hilo_s   = head_valid_s & head_s.hilo;
  assign p_gpr_s    = gpr_req(pipe_wreg_i, pipe_wa_i);
  assign p_hilo_s   = pipe_whilo_i;
  assign conflict_s = (h_gpr_s & p_gpr_s) | (h_hilo_s & p_hilo_s);

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q  <= ARB_PIPE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Any non-conflicting cycle retires the head (an r0 head just drops out).
  always_comb begin
    state_d   = ARB_PIPE;
    starve_d  = '0;
    pop_s     = 1'b0;
    head_en_s = 1'b0;
    pipe_en_s = 1'b0;
    stall_s   = 1'b0;
    if (cpu_rst) begin
      pipe_en_s = 1'b0;
    end else if (!conflict_s) begin
      pipe_en_s = 1'b1;
      head_en_s = head_valid_s;
      pop_s     = head_valid_s;
    end else if (state_q == ARB_LAT) begin
      head_en_s = 1'b1;
      pop_s     = 1'b1;
      stall_s   = 1'b1;
    end else begin
      pipe_en_s = 1'b1;
      if (starve_q == STARVE_LAST) begin
        state_d  = ARB_LAT;
        starve_d = starve_q;
      end else begin
        state_d  = ARB_PIPE;
        starve_d = starve_q + STV_W'(1);
      end
    end
  end

  always_comb begin
    rf_we_o   = 1'b0;
    rf_wa_o   = 5'd0;
    rf_wd_o   = ZERO_WORD;
    hilo_we_o = 1'b0;
    hi_o      = ZERO_WORD;
    lo_o      = ZERO_WORD;
    if (head_en_s && h_gpr_s) begin
      rf_we_o = 1'b1;
      rf_wa_o = head_s.wa;
      rf_wd_o = head_s.data[REG_BUS-1:0];
    end else if (pipe_en_s && p_gpr_s) begin
      rf_we_o = 1'b1;
      rf_wa_o = pipe_wa_i;
      rf_wd_o = pipe_wd_i;
    end else begin
      rf_we_o = 1'b0;
    end
    if (head_en_s && h_hilo_s) begin
      hilo_we_o = 1'b1;
      hi_o      = head_s.data[DOUBLE_REG_BUS-1:REG_BUS];
      lo_o      = head_s.data[REG_BUS-1:0];
    end else if (pipe_en_s && p_hilo_s) begin
      hilo_we_o = 1'b1;
      hi_o      = pipe_dhilo_i[DOUBLE_REG_BUS-1:REG_BUS];
      lo_o      = pipe_dhilo_i[REG_BUS-1:0];
    end else begin
      hilo_we_o = 1'b0;
    end
  end

  assign wb_stall_o  = stall_s;
  assign lat_ready_o = ~cpu_rst & ~fifo_full_s;
  assign hilo_busy_o = ~cpu_rst & fifo_busy_s;
  assign lat_cnt_o   = cpu_rst ? {CNT_W{1'b0}} : fifo_cnt_s;

endmodule
